mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: data and address width.
REQ-002 Parameter TIMEOUT, default 16: maximum ISSUE cycles to wait for mem_ack before abort; minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 req0/req1  input  1  access request from port 0 (instruction fetch) and port 1 (load/store).
REQ-006 we0/we1  input  1  write request (1) or read request (0), per port.
REQ-007 addr0/addr1  input  WIDTH  byte address, per port.
REQ-008 wdata0/wdata1  input  WIDTH  store data, per port.
REQ-009 mode0/mode1  input  3  addrmode (byte/half/word, signed/unsigned), passed through unchanged.
REQ-010 ready0/ready1  output  1  request accepted this cycle, combinational.
REQ-011 rvalid0/rvalid1  output  1  one-cycle response pulse, registered.
REQ-012 rdata  output  WIDTH  read data, valid with rvalid0/rvalid1.
REQ-013 err  output  1  timeout flag, valid with rvalid0/rvalid1.
REQ-014 mem_req, mem_we  output  1  memory-side request strobe and write enable.
REQ-015 mem_addr, mem_wdata  output  WIDTH; mem_mode  output  3  registered copies of the accepted request.
REQ-016 mem_ack  input  1; mem_rdata  input  WIDTH  memory completion strobe and read data.

Function
REQ-017 The FSM SHALL have two states: IDLE and ISSUE.
REQ-018 In IDLE with any req high, the arbiter SHALL assert exactly one readyN in the same cycle, latch that port's we/addr/wdata/mode and port id, and enter ISSUE.
REQ-019 On contention, the arbiter SHALL grant the port not granted last (round-robin); single requester wins immediately.
REQ-020 The last-grant register SHALL reset to 0, so port 1 wins the first simultaneous request after reset.
REQ-021 In ISSUE, mem_req SHALL be 1 and mem_* outputs SHALL hold the latched values; in IDLE, mem_req SHALL be 0.
REQ-022 When mem_ack=1 in ISSUE: next cycle rvalidN=1 for the latched port, rdata=mem_rdata captured on that edge (writes: rdata=0), err=0, state to IDLE.
REQ-023 Minimum latency SHALL be: request accepted cycle 0, mem_req cycles 1..k, rvalid cycle k+1 where mem_ack first high in cycle k.
REQ-024 A new request SHALL be acceptable in the same cycle rvalid is asserted (back-to-back throughput one access per 2 cycles with single-cycle ack).
REQ-025 A wait counter SHALL count ISSUE cycles; if TIMEOUT cycles elapse with no mem_ack, the arbiter SHALL drop mem_req, pulse rvalidN with err=1, rdata=0, return to IDLE.
REQ-026 mem_ack in IDLE SHALL be ignored; mem_ack in the final timeout cycle SHALL complete normally (err=0).
REQ-027 readyN SHALL be 0 while in ISSUE regardless of req; requesters SHALL hold req and fields stable until ready.
REQ-028 rvalid0 and rvalid1 SHALL never be high together; ready0 and ready1 SHALL never be high together.
REQ-029 req inputs SHALL not be latched when deasserted before ready; no request queueing beyond the one in flight.

Reset
REQ-030 While rst=0: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_mode=0, rvalid0=rvalid1=0, rdata=0, err=0, wait counter=0, last-grant=0, ready0=ready1=0.
REQ-031 Reset asserted mid-ISSUE SHALL abort the access immediately with no rvalid pulse after release.
REQ-032 First request SHALL be acceptable in the first rising edge after rst returns to 1.

Verification
REQ-033 Single read: req1, we1=0, addr1=0x100, mem_ack in cycle 1 with mem_rdata=0xDEADBEEF -> ready1 cycle 0, mem_addr=0x100 cycle 1, rvalid1 and rdata=0xDEADBEEF cycle 2.
REQ-034 Contention after reset: req0 and req1 both high, all acks immediate -> grant order 1,0,1,0 across four accesses, ready never on both ports.
REQ-035 Store: req0, we0=1, addr0=0x20, wdata0=0x12345678, mode0=3'b010 -> mem_we=1, mem_wdata=0x12345678, mem_mode=3'b010 during ISSUE, rvalid0 with rdata=0.
REQ-036 Timeout: TIMEOUT=16, mem_ack never asserted -> mem_req high cycles 1..16, rvalidN with err=1 cycle 17; ack in cycle 16 instead -> err=0.
REQ-037 Reset mid-access: rst=0 during ISSUE cycle 2 -> all outputs 0 immediately, no rvalid after release, next req accepted normally.
REQ-038 Stray ack: mem_ack=1 in IDLE with no req -> no rvalid, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with one access in flight and an ack timeout.
// Port 0 is instruction fetch, port 1 is load/store; responses return as one-cycle rvalid pulses.
module mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [2:0]       mode0,
  input  logic [2:0]       mode1,
  output logic             ready0,
  output logic             ready1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic             err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [2:0]       mem_mode,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t          state_r;
  logic            last_grant_r;
  logic            port_r;
  logic [CW-1:0]   wait_cnt_r;
  logic            grant0_s;
  logic            grant1_s;

  // Grant selection: port 1 wins unless port 0 is alone or port 1 was granted last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst && (state_r == IDLE)) begin
      if (req1 && (!req0 || !last_grant_r)) begin
        grant1_s = 1'b1;
      end else if (req0) begin
        grant0_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign ready0 = grant0_s;
  assign ready1 = grant1_s;

  // Arbiter FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
      port_r       <= 1'b0;
      wait_cnt_r   <= {CW{1'b0}};
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {WIDTH{1'b0}};
      mem_wdata    <= {WIDTH{1'b0}};
      mem_mode     <= 3'b000;
      rvalid0      <= 1'b0;
      rvalid1      <= 1'b0;
      rdata        <= {WIDTH{1'b0}};
      err          <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            port_r       <= grant1_s;
            last_grant_r <= grant1_s;
            mem_req      <= 1'b1;
            mem_we       <= grant1_s ? we1 : we0;
            mem_addr     <= grant1_s ? addr1 : addr0;
            mem_wdata    <= grant1_s ? wdata1 : wdata0;
            mem_mode     <= grant1_s ? mode1 : mode0;
            wait_cnt_r   <= {CW{1'b0}};
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // An ack in the last allowed cycle still wins over the timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            rvalid0 <= ~port_r;
            rvalid1 <= port_r;
            rdata   <= mem_we ? {WIDTH{1'b0}} : mem_rdata;
            err     <= 1'b0;
            state_r <= IDLE;
          end else if (wait_cnt_r == CW'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            rvalid0 <= ~port_r;
            rvalid1 <= port_r;
            rdata   <= {WIDTH{1'b0}};
            err     <= 1'b1;
            state_r <= IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
